// File: rtl/word_match_pipe_pkg.sv
// Shared widths and constants for the word match pipeline.
// Imported by the top level of the block.
package word_match_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/equality_32.sv
// 32-bit equality comparator.
// Used as the S1 to S2 compare stage.
module equality_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        eq
);

    assign eq = (a == b);

endmodule

// File: rtl/word_match_pipe.sv
// Two-stage valid/ready pipeline matching words against a pattern.
// Tags each result with its stream index and keeps saturating totals.
module word_match_pipe #(
    parameter int DATA_W = word_match_pipe_pkg::DATA_W,
    parameter int CNT_W  = word_match_pipe_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pat_we,
    input  logic [DATA_W-1:0] pat_data,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic              out_hit,
    output logic [CNT_W-1:0]  out_idx,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  match_count
);

    import word_match_pipe_pkg::*;

    localparam logic [CNT_W-1:0] SAT = CNT_MAX;

    logic [DATA_W-1:0] pat_reg;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [CNT_W-1:0]  s1_idx;

    logic              s2_valid;
    logic              s2_hit;
    logic [CNT_W-1:0]  s2_idx;

    logic s1_hit;
    logic s2_free;
    logic s1_move;
    logic accept;
    logic hit_done;

    equality_32 u_eq (
        .a  (s1_data),
        .b  (pat_reg),
        .eq (s1_hit)
    );

    // Handshake: S1 may refill when it drains, S2 frees on consume.
    always_comb begin
        s2_free  = ~s2_valid | out_ready;
        s1_move  = s1_valid & s2_free;
        in_ready = (~s1_valid | s2_free) & ~pat_we;
        accept   = in_valid & in_ready;
        hit_done = s2_valid & out_ready & s2_hit;
    end

    assign out_valid = s2_valid;
    assign out_hit   = s2_hit;
    assign out_idx   = s2_idx;

    // Pattern register; a word leaving S1 this edge sees the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_reg <= '0;
        end else if (pat_we) begin
            pat_reg <= pat_data;
        end
    end

    // S1: capture accepted word tagged with the pre-increment count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_idx   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_idx   <= word_count;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: take the compare result from S1, or drain on consume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_hit   <= 1'b0;
            s2_idx   <= '0;
        end else if (s1_move) begin
            s2_valid <= 1'b1;
            s2_hit   <= s1_hit;
            s2_idx   <= s1_idx;
        end else if (s2_free) begin
            s2_valid <= 1'b0;
        end
    end

    // Saturating totals; clear takes priority over increments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count  <= '0;
            match_count <= '0;
        end else if (clr) begin
            word_count  <= '0;
            match_count <= '0;
        end else begin
            if (accept && word_count != SAT) begin
                word_count <= word_count + 1'b1;
            end
            if (hit_done && match_count != SAT) begin
                match_count <= match_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_word_match_pipe.sv
// Self-checking bench for word_match_pipe.
// Queue-based reference model plus directed literal checks.
module tb_word_match_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        pat_we;
    logic [31:0] pat_data;
    logic        clr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_hit;
    logic [15:0] out_idx;
    logic        out_ready;
    logic [15:0] word_count;
    logic [15:0] match_count;

    int vectors = 0;
    int miscompares = 0;

    word_match_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .pat_we      (pat_we),
        .pat_data    (pat_data),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_hit     (out_hit),
        .out_idx     (out_idx),
        .out_ready   (out_ready),
        .word_count  (word_count),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit [15:0] sat(input bit [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Reference model: in-flight words in order, with accept edge.
    typedef struct {
        bit [15:0] idx;
        bit        hit;
        int        acc;
    } ent_t;

    ent_t      q[$];
    bit [31:0] mpat;
    bit [15:0] mwc;
    bit [15:0] mmc;
    int        cyc = 0;

    initial begin
        bit vis;
        bit rdy;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_word_count", word_count, 0);
                chk("rst_match_count", match_count, 0);
                q.delete();
                mpat = 0;
                mwc  = 0;
                mmc  = 0;
            end else begin
                vis = (q.size() > 0) && (q[0].acc < cyc);
                rdy = !pat_we && (q.size() < 2 || out_ready);
                chk("out_valid", out_valid, vis);
                if (vis) begin
                    chk("out_idx", out_idx, q[0].idx);
                    chk("out_hit", out_hit, q[0].hit);
                end
                chk("in_ready", in_ready, rdy);
                chk("word_count", word_count, mwc);
                chk("match_count", match_count, mmc);
                if (vis && out_ready) begin
                    if (q[0].hit) mmc = sat(mmc);
                    void'(q.pop_front());
                end
                if (in_valid && rdy) begin
                    q.push_back(ent_t'{idx: mwc,
                                       hit: (in_data == mpat),
                                       acc: cyc + 1});
                    mwc = sat(mwc);
                end
                if (clr) begin
                    mwc = 0;
                    mmc = 0;
                end
                if (pat_we) mpat = pat_data;
            end
            cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pat_we    = 1'b0;
        pat_data  = '0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic load_pat(input logic [31:0] p);
        pat_we   = 1'b1;
        pat_data = p;
        step();
        pat_we   = 1'b0;
    endtask

    logic [31:0] t1_w[4] = '{32'h1108F302, 32'hFF28FF00,
                             32'hFF28F1F0, 32'hFF28FF00};
    logic        t1_h[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // Reset, then the basic streaming case.
        do_reset();
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        load_pat(32'hFF28FF00);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = t1_w[i];
            step();
            if (i > 0) begin
                chk("t1_hit", out_hit, t1_h[i-1]);
                chk("t1_idx", out_idx, i - 1);
            end
        end
        in_valid = 1'b0;
        step();
        chk("t1_hit3", out_hit, t1_h[3]);
        chk("t1_idx3", out_idx, 3);
        step();
        chk("t1_wc", word_count, 4);
        chk("t1_mc", match_count, 2);

        // Zero pattern after reset.
        do_reset();
        in_valid = 1'b1;
        in_data  = 32'h0;
        step();
        in_valid = 1'b0;
        step();
        chk("t2_valid", out_valid, 1);
        chk("t2_hit", out_hit, 1);
        chk("t2_idx", out_idx, 0);

        // Backpressure: two held, third waits.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data   = 32'h22;
        step();
        in_data   = 32'h33;
        chk("t3_ready_full", in_ready, 0);
        step();
        chk("t3_idx_hold", out_idx, 0);
        step();
        chk("t3_idx_hold2", out_idx, 0);
        chk("t3_valid_hold", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("t3_ready_rel", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("t3_idx1", out_idx, 1);
        step();
        chk("t3_idx2", out_idx, 2);
        step();
        step();
        chk("t3_wc", word_count, 3);

        // Pattern write while a word leaves S1.
        do_reset();
        load_pat(32'hFF28FF00);
        in_valid = 1'b1;
        in_data  = 32'hFF28FF00;
        step();
        pat_we   = 1'b1;
        pat_data = 32'hFF00FF00;
        in_data  = 32'hFF00FF00;
        #1;
        chk("t4_ready_patwe", in_ready, 0);
        step();
        pat_we = 1'b0;
        chk("t4_old_hit", out_hit, 1);
        chk("t4_old_idx", out_idx, 0);
        step();
        in_valid = 1'b0;
        step();
        chk("t4_new_hit", out_hit, 1);
        chk("t4_new_idx", out_idx, 1);

        // Counter saturation.
        do_reset();
        load_pat(32'hA5A5A5A5);
        in_valid = 1'b1;
        in_data  = 32'hA5A5A5A5;
        repeat (65537) step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("t5_wc_sat", word_count, 16'hFFFF);
        chk("t5_mc_sat", match_count, 16'hFFFF);

        // Clear coincident with a delivered hit.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        step();
        chk("t6_pending", out_valid, 1);
        clr       = 1'b1;
        out_ready = 1'b1;
        step();
        clr = 1'b0;
        chk("t6_mc_clr", match_count, 0);
        chk("t6_wc_clr", word_count, 0);

        // Asynchronous reset with both stages full.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h5;
        step();
        step();
        in_valid = 1'b0;
        chk("t7_full", out_valid, 1);
        chk("t7_wc_pre", word_count, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("t7_valid_rst", out_valid, 0);
        chk("t7_wc_rst", word_count, 0);
        chk("t7_mc_rst", match_count, 0);
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("t7_empty", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
